axi_lite_regfile: RTL and testbench

AXI4-Lite slave endpoint: a bank of NUM_REGS 32-bit read/write control registers answering the transactions routed to it by axi_lite_crossbar on one of its slave-side ports. It accepts write address and write data independently, commits byte-strobed writes, and returns B/R responses. Register contents and per-register write pulses are exported to fabric logic.

---
 rtl/axi_lite_pkg.sv | 34 +++
 rtl/axi4_lite_if.sv | 50 +++++
 rtl/axi_lite_hold.sv | 34 +++
 rtl/axi_lite_regfile.sv | 146 ++++++++++++++
 tb/tb_axi_lite_regfile.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite types and constants for the crossbar and its endpoints.
// Latency: none (declarations and a combinational helper only).
// Backpressure: not applicable.
package axi_lite_pkg;

  localparam int AXIL_DATA_WIDTH = 32;
  localparam int AXIL_STRB_WIDTH = AXIL_DATA_WIDTH / 8;

  typedef logic [1:0] axil_resp_t;

  localparam axil_resp_t RESP_OKAY   = 2'b00;
  localparam axil_resp_t RESP_SLVERR = 2'b10;

  // Write data beat as held inside an endpoint: data plus its byte strobes.
  typedef struct packed {
    logic [AXIL_DATA_WIDTH-1:0] data;
    logic [AXIL_STRB_WIDTH-1:0] strb;
  } axil_w_t;

  // Merge new_dat into old_dat byte by byte wherever strb is set.
  function automatic logic [AXIL_DATA_WIDTH-1:0] apply_strb(
    input logic [AXIL_DATA_WIDTH-1:0] old_dat,
    input logic [AXIL_DATA_WIDTH-1:0] new_dat,
    input logic [AXIL_STRB_WIDTH-1:0] strb
  );
    logic [AXIL_DATA_WIDTH-1:0] merged;
    merged = old_dat;
    for (int j = 0; j < AXIL_STRB_WIDTH; j++) begin
      if (strb[j]) merged[8*j +: 8] = new_dat[8*j +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite channel bundle (AW, W, B, AR, R) with master and slave views.
// Latency: none, wires only.
// Backpressure: plain valid/ready per channel.
interface axi4_lite_if
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0]      awaddr;
  logic [2:0]                 awprot;
  logic                       awvalid;
  logic                       awready;

  logic [AXIL_DATA_WIDTH-1:0] wdata;
  logic [AXIL_STRB_WIDTH-1:0] wstrb;
  logic                       wvalid;
  logic                       wready;

  axil_resp_t                 bresp;
  logic                       bvalid;
  logic                       bready;

  logic [ADDR_WIDTH-1:0]      araddr;
  logic [2:0]                 arprot;
  logic                       arvalid;
  logic                       arready;

  logic [AXIL_DATA_WIDTH-1:0] rdata;
  axil_resp_t                 rresp;
  logic                       rvalid;
  logic                       rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

endinterface

// File: rtl/axi_lite_hold.sv
// One-entry holding register: captures a beat on valid/ready, keeps it until cleared.
// Latency: held/hold_dat update one edge after the accepting handshake.
// Backpressure: ready is low while an entry is held or while block is asserted.
module axi_lite_hold #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_vld,
  output logic             up_rdy,
  input  logic [WIDTH-1:0] up_dat,
  input  logic             block,
  input  logic             clr,
  output logic             held,
  output logic [WIDTH-1:0] hold_dat
);

  assign up_rdy = !held && !block;

  // Capture on handshake; clr empties the entry. clr only fires while held,
  // when up_rdy is already low, so the two never compete.
  always_ff @(posedge clk) begin
    if (rst) begin
      held     <= 1'b0;
      hold_dat <= '0;
    end else if (clr) begin
      held     <= 1'b0;
    end else if (up_vld && up_rdy) begin
      held     <= 1'b1;
      hold_dat <= up_dat;
    end
  end

endmodule

// File: rtl/axi_lite_regfile.sv
// AXI4-Lite register bank: NUM_REGS byte-strobed 32-bit registers, exported with write pulses.
// Latency: write commits one edge after the later of AW/W; read data one edge after AR.
// Backpressure: AW/W stall while held or BVALID pending; AR stalls while RVALID pending.
module axi_lite_regfile
  import axi_lite_pkg::*;
#(
  parameter int                         NUM_REGS      = 8,
  parameter int                         SI_ADDR_WIDTH = 12,
  parameter logic [AXIL_DATA_WIDTH-1:0] RESET_VALUE   = 32'h0000_0000
) (
  input  logic                                ACLK,
  input  logic                                ARESET,
  axi4_lite_if.slave                          s_axi,
  output logic [NUM_REGS*AXIL_DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]                 wr_pulse
);

  localparam int             IDX_W = SI_ADDR_WIDTH - 2;
  localparam logic [IDX_W:0] NREGS = (IDX_W+1)'(NUM_REGS);

  if (NUM_REGS < 1 || NUM_REGS > 2**(SI_ADDR_WIDTH-2)) begin : g_bad_cfg
    $fatal(1, "axi_lite_regfile: NUM_REGS out of range for SI_ADDR_WIDTH");
  end

  logic [AXIL_DATA_WIDTH-1:0] regs [NUM_REGS];

  logic                       aw_rdy;
  logic                       aw_held;
  logic [IDX_W-1:0]           aw_idx;
  logic                       aw_hit;

  logic                       w_rdy;
  logic                       w_held;
  axil_w_t                    w_in;
  axil_w_t                    w_hold;

  logic                       commit;
  logic                       b_vld;
  axil_resp_t                 b_resp;

  logic [IDX_W-1:0]           ar_idx;
  logic                       ar_hit;
  logic                       ar_fire;
  logic [AXIL_DATA_WIDTH-1:0] rd_dat;
  logic                       r_vld;
  logic [AXIL_DATA_WIDTH-1:0] r_dat;
  axil_resp_t                 r_resp;

  // Protection bits and address bits above the decoded window carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr, s_axi.araddr};

  assign w_in = '{data: s_axi.wdata, strb: s_axi.wstrb};

  axi_lite_hold #(.WIDTH(IDX_W)) u_aw_hold (
    .clk      (ACLK),
    .rst      (ARESET),
    .up_vld   (s_axi.awvalid),
    .up_rdy   (aw_rdy),
    .up_dat   (s_axi.awaddr[SI_ADDR_WIDTH-1:2]),
    .block    (b_vld),
    .clr      (commit),
    .held     (aw_held),
    .hold_dat (aw_idx)
  );

  axi_lite_hold #(.WIDTH($bits(axil_w_t))) u_w_hold (
    .clk      (ACLK),
    .rst      (ARESET),
    .up_vld   (s_axi.wvalid),
    .up_rdy   (w_rdy),
    .up_dat   (w_in),
    .block    (b_vld),
    .clr      (commit),
    .held     (w_held),
    .hold_dat (w_hold)
  );

  assign commit = aw_held && w_held && !b_vld;
  assign aw_hit = {1'b0, aw_idx} < NREGS;

  assign ar_idx  = s_axi.araddr[SI_ADDR_WIDTH-1:2];
  assign ar_hit  = {1'b0, ar_idx} < NREGS;
  assign ar_fire = s_axi.arvalid && !r_vld;

  assign s_axi.awready = aw_rdy;
  assign s_axi.wready  = w_rdy;
  assign s_axi.bvalid  = b_vld;
  assign s_axi.bresp   = b_resp;
  assign s_axi.arready = !r_vld;
  assign s_axi.rvalid  = r_vld;
  assign s_axi.rdata   = r_dat;
  assign s_axi.rresp   = r_resp;

  // Read mux over the current (pre-commit) register values; misses read as zero.
  always_comb begin
    rd_dat = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ar_idx == IDX_W'(i)) rd_dat = regs[i];
    end
  end

  // Commit a held write into the bank, raise the pulse and the B response.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VALUE;
      wr_pulse <= '0;
      b_vld    <= 1'b0;
      b_resp   <= RESP_OKAY;
    end else begin
      wr_pulse <= '0;
      if (commit) begin
        b_vld  <= 1'b1;
        b_resp <= aw_hit ? RESP_OKAY : RESP_SLVERR;
        for (int i = 0; i < NUM_REGS; i++) begin
          if (aw_hit && aw_idx == IDX_W'(i)) begin
            regs[i]     <= apply_strb(regs[i], w_hold.data, w_hold.strb);
            wr_pulse[i] <= 1'b1;
          end
        end
      end else if (b_vld && s_axi.bready) begin
        b_vld <= 1'b0;
      end
    end
  end

  // Capture read data on AR handshake and hold it until the R handshake.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_vld  <= 1'b0;
      r_dat  <= '0;
      r_resp <= RESP_OKAY;
    end else if (ar_fire) begin
      r_vld  <= 1'b1;
      r_dat  <= rd_dat;
      r_resp <= ar_hit ? RESP_OKAY : RESP_SLVERR;
    end else if (r_vld && s_axi.rready) begin
      r_vld <= 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign reg_out[AXIL_DATA_WIDTH*g +: AXIL_DATA_WIDTH] = regs[g];
  end

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Scoreboarded bench for axi_lite_regfile: B/R expectations queued at stimulus time.
// Latency: checks commit at k+1 after the later AW/W edge and RVALID right after AR.
// Backpressure: exercises BREADY stalls and a reset with a pending B response.
module tb_axi_lite_regfile;
  import axi_lite_pkg::*;

  localparam int          NREG    = 8;
  localparam logic [31:0] RST_VAL = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } rd_exp_t;

  logic              aclk;
  logic              areset;
  logic [NREG*32-1:0] reg_out;
  logic [NREG-1:0]    wr_pulse;

  axi4_lite_if #(.ADDR_WIDTH(32)) axi ();

  axi_lite_regfile #(
    .NUM_REGS      (NREG),
    .SI_ADDR_WIDTH (12),
    .RESET_VALUE   (RST_VAL)
  ) dut (
    .ACLK     (aclk),
    .ARESET   (areset),
    .s_axi    (axi),
    .reg_out  (reg_out),
    .wr_pulse (wr_pulse)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] mdl [NREG];
  logic [1:0]  exp_b [$];
  rd_exp_t     exp_r [$];
  logic [1:0]  mon_b;
  rd_exp_t     mon_r;

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Model of a committed write; pushes the B response the DUT owes.
  task automatic expect_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int idx;
    idx = int'(addr[11:2]);
    if (idx < NREG) begin
      for (int j = 0; j < 4; j++) if (strb[j]) mdl[idx][8*j +: 8] = data[8*j +: 8];
      exp_b.push_back(RESP_OKAY);
    end else begin
      exp_b.push_back(RESP_SLVERR);
    end
  endtask

  // Present AW and W together; returns #1 after the edge completing both.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          output int cycles);
    bit aw_done, w_done, aw_fire, w_fire;
    aw_done = 0; w_done = 0; cycles = 0;
    axi.awaddr = addr; axi.awvalid = 1'b1;
    axi.wdata = data; axi.wstrb = strb; axi.wvalid = 1'b1;
    while (!(aw_done && w_done) && cycles < 20) begin
      @(negedge aclk);
      aw_fire = axi.awvalid && axi.awready;
      w_fire  = axi.wvalid && axi.wready;
      tick();
      cycles++;
      if (aw_fire) begin aw_done = 1; axi.awvalid = 1'b0; end
      if (w_fire)  begin w_done = 1;  axi.wvalid = 1'b0;  end
    end
    check("wr_handshake", {62'd0, aw_done, w_done}, 64'd3);
    expect_write(addr, data, strb);
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb);
    bit fire, done;
    int n;
    done = 0; n = 0;
    axi.wdata = data; axi.wstrb = strb; axi.wvalid = 1'b1;
    while (!done && n < 20) begin
      @(negedge aclk);
      fire = axi.wvalid && axi.wready;
      tick();
      n++;
      if (fire) begin done = 1; axi.wvalid = 1'b0; end
    end
    check("w_handshake", done, 1);
  endtask

  task automatic send_aw(input logic [31:0] addr);
    bit fire, done;
    int n;
    done = 0; n = 0;
    axi.awaddr = addr; axi.awvalid = 1'b1;
    while (!done && n < 20) begin
      @(negedge aclk);
      fire = axi.awvalid && axi.awready;
      tick();
      n++;
      if (fire) begin done = 1; axi.awvalid = 1'b0; end
    end
    check("aw_handshake", done, 1);
  endtask

  // Issue AR with an explicit expectation; RVALID must be high right after the handshake edge.
  task automatic do_read_exp(input logic [31:0] addr, input logic [31:0] ed, input logic [1:0] er);
    bit fire, done;
    int n;
    done = 0; n = 0;
    axi.araddr = addr; axi.arvalid = 1'b1;
    exp_r.push_back('{data: ed, resp: er});
    while (!done && n < 20) begin
      @(negedge aclk);
      fire = axi.arvalid && axi.arready;
      tick();
      n++;
      if (fire) begin done = 1; axi.arvalid = 1'b0; end
    end
    check("ar_handshake", done, 1);
    check("rvalid_latency", axi.rvalid, 1);
  endtask

  task automatic do_read(input logic [31:0] addr);
    int idx;
    idx = int'(addr[11:2]);
    if (idx < NREG) do_read_exp(addr, mdl[idx], RESP_OKAY);
    else            do_read_exp(addr, 32'h0, RESP_SLVERR);
  endtask

  // Scoreboard: compare each response beat as it is accepted.
  always @(negedge aclk) begin
    if (!areset) begin
      if (axi.bvalid && axi.bready) begin
        if (exp_b.size() == 0) check("b_unexpected", 1, 0);
        else begin
          mon_b = exp_b.pop_front();
          check("bresp", axi.bresp, mon_b);
        end
      end
      if (axi.rvalid && axi.rready) begin
        if (exp_r.size() == 0) check("r_unexpected", 1, 0);
        else begin
          mon_r = exp_r.pop_front();
          check("rdata", axi.rdata, mon_r.data);
          check("rresp", axi.rresp, mon_r.resp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [31:0] old;

    areset = 1'b1;
    axi.awaddr = '0; axi.awprot = '0; axi.awvalid = 1'b0;
    axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0;
    axi.bready = 1'b1;
    axi.araddr = '0; axi.arprot = '0; axi.arvalid = 1'b0;
    axi.rready = 1'b1;
    for (int i = 0; i < NREG; i++) mdl[i] = RST_VAL;
    repeat (3) tick();
    areset = 1'b0;

    // Reset state
    check("rst_awready", axi.awready, 1);
    check("rst_wready", axi.wready, 1);
    check("rst_arready", axi.arready, 1);
    check("rst_bvalid", axi.bvalid, 0);
    check("rst_rvalid", axi.rvalid, 0);
    check("rst_rdata", axi.rdata, 0);
    check("rst_wr_pulse", wr_pulse, 0);
    for (int i = 0; i < NREG; i++) check("rst_reg_out", reg_out[32*i +: 32], RST_VAL);

    for (int i = 0; i < NREG; i++) do_read(32'(i * 4));

    // Simultaneous AW/W to register 2
    tick();
    do_write(32'h008, 32'hDEADBEEF, 4'hF, cyc);
    check("wr2_bvalid_k", axi.bvalid, 0);
    tick();
    check("wr2_bvalid_k1", axi.bvalid, 1);
    check("wr2_reg_out", reg_out[64 +: 32], 32'hDEADBEEF);
    check("wr2_pulse", wr_pulse, 8'h04);
    tick();
    check("wr2_pulse_clear", wr_pulse, 8'h00);
    do_read(32'h008);

    // W three cycles ahead of AW, partial strobes into register 1
    tick();
    send_w(32'h11223344, 4'b0101);
    check("early_w_wready", axi.wready, 0);
    repeat (3) begin
      tick();
      check("early_w_no_commit", axi.bvalid, 0);
      check("early_w_reg1", reg_out[32 +: 32], 32'h0);
    end
    send_aw(32'h004);
    expect_write(32'h004, 32'h11223344, 4'b0101);
    check("late_aw_bvalid_k", axi.bvalid, 0);
    tick();
    check("late_aw_bvalid_k1", axi.bvalid, 1);
    check("late_aw_reg1", reg_out[32 +: 32], 32'h00220044);
    check("late_aw_pulse", wr_pulse, 8'h02);
    do_read(32'h004);

    // Out-of-range index
    tick();
    do_write(32'h020, 32'hFFFFFFFF, 4'hF, cyc);
    tick();
    check("miss_bvalid", axi.bvalid, 1);
    check("miss_pulse", wr_pulse, 8'h00);
    for (int i = 0; i < NREG; i++) check("miss_reg_out", reg_out[32*i +: 32], mdl[i]);
    do_read(32'h020);

    // BREADY held low for five cycles
    tick();
    axi.bready = 1'b0;
    do_write(32'h00C, 32'h12345678, 4'hF, cyc);
    tick();
    repeat (5) begin
      check("stall_bvalid", axi.bvalid, 1);
      check("stall_bresp", axi.bresp, RESP_OKAY);
      check("stall_awready", axi.awready, 0);
      check("stall_wready", axi.wready, 0);
      tick();
    end
    axi.bready = 1'b1;
    tick();
    check("after_b_bvalid", axi.bvalid, 0);
    check("after_b_awready", axi.awready, 1);
    do_write(32'h010, 32'h0000BEEF, 4'b0011, cyc);
    check("after_b_aw_cycles", cyc, 1);
    tick();
    check("reg4_value", reg_out[128 +: 32], 32'h0000BEEF);

    // Read and commit to register 0 at the same edge
    tick();
    do_write(32'h000, 32'h0F0F0F0F, 4'hF, cyc);
    repeat (2) tick();
    old = mdl[0];
    do_write(32'h000, 32'hA5A5A5A5, 4'hF, cyc);
    do_read_exp(32'h000, old, RESP_OKAY);
    check("same_edge_bvalid", axi.bvalid, 1);
    check("same_edge_reg0", reg_out[0 +: 32], 32'hA5A5A5A5);
    tick();

    // Reset while a B response is pending
    axi.bready = 1'b0;
    do_write(32'h000, 32'h5555AAAA, 4'hF, cyc);
    tick();
    check("pre_rst_bvalid", axi.bvalid, 1);
    exp_b.delete();
    areset = 1'b1;
    tick();
    areset = 1'b0;
    for (int i = 0; i < NREG; i++) mdl[i] = RST_VAL;
    check("mid_rst_bvalid", axi.bvalid, 0);
    check("mid_rst_reg0", reg_out[0 +: 32], RST_VAL);
    check("mid_rst_reg2", reg_out[64 +: 32], RST_VAL);
    check("mid_rst_awready", axi.awready, 1);
    axi.bready = 1'b1;
    do_read(32'h000);
    do_read(32'h008);

    repeat (4) tick();
    check("sb_b_drained", exp_b.size(), 0);
    check("sb_r_drained", exp_r.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
